// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALUop codes and the issue-entry record for the ALU operand issue stage.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int REG_AW = 5;

    localparam logic [OP_W-1:0] ALU_AND = 4'd4;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd5;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd6;
    localparam logic [OP_W-1:0] ALU_NOR = 4'd7;

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } entry_t;

    // Register 0 is hard-wired zero, so a write to it never forwards.
    function automatic logic fwd_hit(input logic v, input logic [REG_AW-1:0] fa, input logic [REG_AW-1:0] ra);
        return v && (fa != '0) && (fa == ra);
    endfunction
endpackage

// File: rtl/alu_fwd_mux.sv
// alu_fwd_mux: replaces an operand with the writeback value when the writeback targets its register.
module alu_fwd_mux
    import alu_pkg::*;
(
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              fwd_valid_i,
    input  logic [REG_AW-1:0] fwd_addr_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    output logic [DATA_W-1:0] data_o
);
    assign data_o = fwd_hit(fwd_valid_i, fwd_addr_i, addr_i) ? fwd_data_i : data_i;
endmodule

// File: rtl/alu_operand_issue.sv
// alu_operand_issue: 2-entry forwarding operand buffer between decode and the ALU.
// Outputs are taken straight from the head register; in_ready depends only on occupancy.
module alu_operand_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [1:0]        count
);
    entry_t      head_q, head_d, tail_q, tail_d;
    entry_t      in_f, head_f, tail_f;
    logic [1:0]  count_q, count_d;
    logic        push, pop;
    logic [REG_AW-1:0] sel_addr [6];
    logic [DATA_W-1:0] sel_data [6];
    logic [DATA_W-1:0] fw_data  [6];

    assign in_ready   = count_q != 2'd2;
    assign out_valid  = count_q != 2'd0;
    assign count      = count_q;
    assign out_a      = head_q.a;
    assign out_b      = head_q.b;
    assign out_alu_op = head_q.op;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // Lanes: 0/1 incoming rs/rt, 2/3 head a/b, 4/5 tail a/b.
    assign sel_addr = '{in_rs_addr, in_rt_addr, head_q.rs, head_q.rt, tail_q.rs, tail_q.rt};
    assign sel_data = '{in_rs_data, in_rt_data, head_q.a, head_q.b, tail_q.a, tail_q.b};

    for (genvar i = 0; i < 6; i++) begin : g_fwd
        alu_fwd_mux u_mux (
            .addr_i     (sel_addr[i]),
            .data_i     (sel_data[i]),
            .fwd_valid_i(fwd_valid),
            .fwd_addr_i (fwd_addr),
            .fwd_data_i (fwd_data),
            .data_o     (fw_data[i])
        );
    end

    always_comb begin
        in_f   = '{rs: in_rs_addr, rt: in_rt_addr, a: fw_data[0], b: fw_data[1], op: in_alu_op};
        head_f = '{rs: head_q.rs, rt: head_q.rt, a: fw_data[2], b: fw_data[3], op: head_q.op};
        tail_f = '{rs: tail_q.rs, rt: tail_q.rt, a: fw_data[4], b: fw_data[5], op: tail_q.op};
    end

    // A head that is being popped without replacement keeps its raw contents so out_* hold.
    always_comb begin
        head_d  = (push && (count_q == 2'd0 || pop)) ? in_f :
                  (pop && count_q == 2'd2)           ? tail_f :
                  (count_q != 2'd0 && !pop)          ? head_f : head_q;
        tail_d  = (push && !pop && count_q == 2'd1) ? in_f : tail_f;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule
